// File: rtl/esp32_osd_spi_writer.sv
// Decodes the SPI byte stream from the ESP32 into OSD buffer writes: enable/disable,
// auto-incrementing block writes and a full-buffer clear.
module esp32_osd_spi_writer #(
   parameter logic [7:0] FILL_CHAR = 8'h20,
   parameter int         ADDR_W    = 12
) (
   input  logic              clk_sys,
   input  logic              rst_n,
   input  logic              spi_cs_active,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              wr_en,
   output logic              osd_enable,
   output logic              busy,
   output logic              cmd_error
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ADDR_HI = 3'd1;
   localparam logic [2:0] ST_ADDR_LO = 3'd2;
   localparam logic [2:0] ST_DATA    = 3'd3;
   localparam logic [2:0] ST_IGNORE  = 3'd4;
   localparam logic [2:0] ST_CLEAR   = 3'd5;

   localparam logic [ADDR_W-1:0] PTR_ZERO = '0;
   localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PTR_LAST = '1;

   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-9:0] r_addr_hi;
   logic              w_accept;

   assign w_accept = rx_valid & spi_cs_active;

   // CLEAR reuses wr_addr as its sweep counter; every other state tracks
   // the transaction and falls back to IDLE as soon as chip-select drops.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_ptr      <= PTR_ZERO;
         r_addr_hi  <= '0;
         wr_addr    <= PTR_ZERO;
         wr_data    <= 8'h00;
         wr_en      <= 1'b0;
         osd_enable <= 1'b0;
         busy       <= 1'b0;
         cmd_error  <= 1'b0;
      end else begin
         wr_en     <= 1'b0;
         cmd_error <= 1'b0;
         if (r_state == ST_CLEAR) begin
            if (wr_addr == PTR_LAST) begin
               busy    <= 1'b0;
               r_state <= spi_cs_active ? ST_IGNORE : ST_IDLE;
            end else begin
               wr_en   <= 1'b1;
               wr_addr <= wr_addr + PTR_ONE;
            end
         end else if (!spi_cs_active) begin
            r_state <= ST_IDLE;
            r_ptr   <= PTR_ZERO;
         end else if (w_accept) begin
            case (r_state)
               ST_IDLE: begin
                  case (rx_data)
                     8'h40: begin
                        osd_enable <= 1'b0;
                        r_state    <= ST_IGNORE;
                     end
                     8'h41: begin
                        osd_enable <= 1'b1;
                        r_state    <= ST_IGNORE;
                     end
                     8'h42: r_state <= ST_ADDR_HI;
                     8'h43: begin
                        busy    <= 1'b1;
                        wr_en   <= 1'b1;
                        wr_addr <= PTR_ZERO;
                        wr_data <= FILL_CHAR;
                        r_state <= ST_CLEAR;
                     end
                     default: begin
                        cmd_error <= 1'b1;
                        r_state   <= ST_IGNORE;
                     end
                  endcase
               end
               ST_ADDR_HI: begin
                  r_addr_hi <= rx_data[ADDR_W-9:0];
                  r_state   <= ST_ADDR_LO;
               end
               ST_ADDR_LO: begin
                  r_ptr   <= {r_addr_hi, rx_data};
                  r_state <= ST_DATA;
               end
               ST_DATA: begin
                  wr_en   <= 1'b1;
                  wr_addr <= r_ptr;
                  wr_data <= rx_data;
                  r_ptr   <= r_ptr + PTR_ONE;
               end
               default: r_state <= ST_IGNORE;
            endcase
         end
      end
   end

endmodule

// File: doc/esp32_osd_spi_writer.md
# esp32_osd_spi_writer

Command decoder between the ESP32 SPI slave byte receiver and the OSD dual-port buffer write port, in the `clk_sys` domain. It parses the per-transaction byte stream and drives the buffer write port: single opcodes, auto-incrementing block writes, and a full-buffer clear. It also owns the `osd_enable` flag used by the video overlay.

## Interface
- `FILL_CHAR`, default 8'h20: byte written to every location by CLEAR.
- `ADDR_W`, default 12: buffer address width; the buffer depth is 2^ADDR_W.
- `clk_sys`  in  1  system clock (50 MHz).
- `rst_n`  in  1  asynchronous, active-low reset.
- `spi_cs_active`  in  1  high for the duration of an SPI transaction; synchronous to `clk_sys`.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `wr_addr`  out  ADDR_W  buffer write address.
- `wr_data`  out  8  buffer write data.
- `wr_en`  out  1  buffer write strobe, one cycle per byte.
- `osd_enable`  out  1  OSD overlay visible.
- `busy`  out  1  high while CLEAR is running.
- `cmd_error`  out  1  one-cycle pulse when an unknown opcode arrives.

## Operation
- A byte is accepted only when `rx_valid=1` and `spi_cs_active=1`. A strobe arriving while `spi_cs_active=0` is discarded.
- The first accepted byte of a transaction is the opcode:
  - 0x40: `osd_enable` goes to 0.
  - 0x41: `osd_enable` goes to 1.
  - 0x42: WRITE. The next byte is `addr_hi`; only bits [ADDR_W-9:0] are used and the rest are ignored. The byte after that is `addr_lo`. Every following byte is written at the pointer, then the pointer increments modulo 2^ADDR_W (4095 wraps to 0).
  - 0x43: CLEAR. Writes `FILL_CHAR` to addresses 0 through 2^ADDR_W-1 in ascending order, one per cycle.
  - Any other value: pulses `cmd_error` and the rest of the transaction is ignored.
- After 0x40 or 0x41, the remaining bytes of the transaction are ignored.
- States: IDLE, ADDR_HI, ADDR_LO, DATA, IGNORE, CLEAR.
- IDLE:
  - On opcode 0x42, go to ADDR_HI.
  - On 0x43, go to CLEAR.
  - On 0x40, 0x41 or an unknown opcode, go to IGNORE.
- ADDR_HI goes to ADDR_LO on the next accepted byte. ADDR_LO goes to DATA on the next accepted byte.
- DATA stays in DATA for each data byte.
- When `spi_cs_active=0`, every state except CLEAR returns to IDLE on the next edge. A partial address header is discarded, and the pointer is not retained across transactions.
- CLEAR cannot be aborted by `spi_cs_active` dropping. Bytes arriving during CLEAR are dropped. When CLEAR ends it goes to IGNORE if `spi_cs_active=1`, otherwise to IDLE.
- `osd_enable` is retained across transactions and across CLEAR. Only 0x40, 0x41 or reset change it.

## Timing
- Reset (`rst_n=0`, asynchronous) immediately forces:
  - `wr_addr=0`, `wr_data=0`, `wr_en=0`
  - `osd_enable=0`, `busy=0`, `cmd_error=0`
  - state IDLE, pointer 0
- Reset mid-CLEAR stops the fill instantly; buffer contents are left partially cleared.
- All outputs are registered. An accepted byte in cycle N takes effect in cycle N+1:
  - a WRITE data byte gives `wr_en=1`, `wr_addr` = pointer and `wr_data` = byte in cycle N+1, and the pointer holds pointer+1 from N+1;
  - 0x40 or 0x41 updates `osd_enable` in N+1;
  - an unknown opcode gives `cmd_error=1` in N+1 for exactly one cycle.
- `wr_en` is 0 in every cycle not listed above and not part of CLEAR. `wr_addr` and `wr_data` hold their last values while `wr_en=0`.
- Back-to-back `rx_valid` strobes on consecutive cycles must each produce one write, with no loss.
- CLEAR opcode accepted in cycle N:
  - `busy=1` in cycles N+1 through N+2^ADDR_W;
  - `wr_en=1` in the same cycles, with `wr_addr` = 0, 1, …, 2^ADDR_W-1 and `wr_data=FILL_CHAR`;
  - `busy=0` and `wr_en=0` at N+2^ADDR_W+1.
- A byte accepted in the same cycle that `spi_cs_active` drops is discarded, and the state goes to IDLE.

## Test plan
- Reset, then the sequence 0x41 → `osd_enable=1` one cycle after the opcode strobe. Next transaction 0x40 → `osd_enable=0`. `wr_en` stays 0 throughout.
- WRITE 0x42, 0x01, 0x20, 0x48, 0x49 with strobes 1 cycle apart → two `wr_en` pulses on consecutive cycles: (0x120, 0x48) then (0x121, 0x49).
- WRITE header 0x0F, 0xFF, then 3 data bytes → writes land at 0xFFF, 0x000, 0x001. A header byte of 0xFF also selects 0xFFF, because the upper nibble is ignored.
- CLEAR 0x43, then `spi_cs_active` drops 10 cycles later while 5 further bytes are strobed → exactly 4096 writes of 0x20 at addresses 0..4095, `busy` high 4096 cycles, then IDLE.
- Unknown opcode 0x55 followed by 0x42, 0x00, 0x00, 0xAA in the same transaction → one `cmd_error` pulse and no writes. A new transaction carrying 0x42, 0x00, 0x00, 0xAA then writes (0x000, 0xAA).
- `rst_n` asserted during DATA and during CLEAR → all outputs 0 immediately. After release, the first byte is treated as an opcode.
